// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: bundles the sequencer's request, operand stream, DSP48A1 A/B/OPMODE/P and
// result handshake signals.
//   master : the sequencer (dsp_mac_seq)
//   slave  : the environment (data mover + slice + result consumer)
// Signals:
//   start, len[4:0]                  request pulse and vector length
//   busy                             sequencer not idle
//   in_valid, in_ready, in_a, in_b   signed 18-bit operand pair stream
//   dsp_a, dsp_b, dsp_opmode         registered drive into the slice
//   dsp_p                            slice P output
//   res_valid, res_ready, res_data   48-bit signed dot-product result
interface dsp_mac_seq_if;
    logic               start;
    logic [4:0]         len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] in_a;
    logic signed [17:0] in_b;
    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic signed [47:0] dsp_p;
    logic               res_valid;
    logic               res_ready;
    logic signed [47:0] res_data;

    modport master (
        input  start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        output busy, in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
    );

    modport slave (
        output start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        input  busy, in_ready, dsp_a, dsp_b, dsp_opmode, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences one DSP48A1 slice (A1REG/B1REG/MREG/PREG/OPMODEREG=1) as a
// dot-product engine. Streams up to 16 signed operand pairs into A/B, issues a per-slot
// OPMODE (first product loads P, later ones accumulate), waits for the slice pipeline to
// drain, then returns P on a valid/ready result port.
// Parameters:
//   LAT       cycles from an operand on dsp_a/dsp_b to its contribution on dsp_p
//   OPM_SKEW  register stages between a slot's operands and its dsp_opmode
// Ports:
//   clk, rst  single clock, asynchronous active-high reset
//   abort     (only when DSP_MAC_ABORT_EN is defined) discard the operation in FEED/DRAIN
//   bus       dsp_mac_seq_if.master: request, operand stream, slice drive, result
// Build option: define DSP_MAC_ABORT_EN to add the abort input.
module dsp_mac_seq #(
    parameter int unsigned LAT      = 3,
    parameter int unsigned OPM_SKEW = 1
) (
    input logic           clk,
    input logic           rst,
`ifdef DSP_MAC_ABORT_EN
    input logic           abort,
`endif
    dsp_mac_seq_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StHold} state_e;

    localparam int unsigned    DrainLen  = LAT + OPM_SKEW;
    localparam int unsigned    DrainW    = $clog2(DrainLen + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainLen - 1);

    localparam logic [7:0] OpmIdle  = 8'h00;  // X=0, Z=0
    localparam logic [7:0] OpmFirst = 8'h01;  // X=M, Z=0: load first product
    localparam logic [7:0] OpmAcc   = 8'h09;  // X=M, Z=P: accumulate

    state_e             state_q;
    logic [4:0]         rem_q;
    logic               issued_q;
    logic [DrainW-1:0]  drain_cnt_q;
    logic               busy_q;
    logic               in_ready_q;
    logic               res_valid_q;
    logic signed [17:0] a_q;
    logic signed [17:0] b_q;
    logic signed [47:0] res_q;
    // [0] is the slot opmode aligned with a_q/b_q; [OPM_SKEW] drives the slice.
    logic [7:0]         opm_pipe_q [OPM_SKEW+1];

    logic       abort_req;
    logic [4:0] len_clamped;
    logic       xfer;

`ifdef DSP_MAC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign len_clamped = (bus.len > 5'd16) ? 5'd16 : bus.len;
    assign xfer        = bus.in_valid & in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            issued_q    <= 1'b0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            for (int unsigned i = 0; i <= OPM_SKEW; i++) begin
                opm_pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i <= OPM_SKEW; i++) begin
                opm_pipe_q[i] <= opm_pipe_q[i-1];
            end
            // Every slot carries zero operands unless an operand is transferred.
            a_q           <= '0;
            b_q           <= '0;
            opm_pipe_q[0] <= OpmIdle;

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q   <= 1'b1;
                        issued_q <= 1'b0;
                        if (len_clamped == 5'd0) begin
                            state_q     <= StHold;
                            res_valid_q <= 1'b1;
                            res_q       <= '0;
                        end else begin
                            state_q    <= StFeed;
                            rem_q      <= len_clamped;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                StFeed: begin
                    if (abort_req) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        rem_q      <= '0;
                        issued_q   <= 1'b0;
                    end else if (xfer) begin
                        a_q           <= bus.in_a;
                        b_q           <= bus.in_b;
                        opm_pipe_q[0] <= issued_q ? OpmAcc : OpmFirst;
                        issued_q      <= 1'b1;
                        rem_q         <= rem_q - 5'd1;
                        if (rem_q == 5'd1) begin
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= StDrain;
                        end
                    end else begin
                        // Bubble: zero product keeps P once accumulation has started.
                        opm_pipe_q[0] <= issued_q ? OpmAcc : OpmIdle;
                    end
                end

                StDrain: begin
                    if (abort_req) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        issued_q    <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        opm_pipe_q[0] <= OpmAcc;
                        // Last product lands on dsp_p in the final drain cycle.
                        if (drain_cnt_q == DrainLast) begin
                            res_q       <= bus.dsp_p;
                            res_valid_q <= 1'b1;
                            drain_cnt_q <= '0;
                            state_q     <= StHold;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                end

                StHold: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.dsp_a      = a_q;
    assign bus.dsp_b      = b_q;
    assign bus.dsp_opmode = opm_pipe_q[OPM_SKEW];
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_q;

endmodule
